// File: rtl/vec_reduce_ctrl.sv
// Chunked vector-sum sequencer: streams Elements-wide int8 chunks into an external
// pipelined adder tree and accumulates the tree's 8-bit partial sums into a wide result.
module vec_reduce_ctrl #(
   parameter int Elements    = 12,
   parameter int VecLen      = 48,
   parameter int TreeLatency = 3,
   parameter int AccWidth    = 16
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [Elements-1:0][7:0]     in_data,
   output logic [Elements-1:0][7:0]     tree_in,
   input  logic [7:0]                   tree_out,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [AccWidth-1:0]          out_data,
   output logic                         busy
);

   localparam int NumChunks = VecLen / Elements;
   localparam int CntW      = $clog2(NumChunks + 1);
   localparam logic [CntW-1:0] LastIdx = CntW'(NumChunks - 1);

   typedef enum logic [1:0] {
      ST_FEED  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e                      state_q, state_d;
   logic [TreeLatency:0]        tag_q, tag_d;
   logic [Elements-1:0][7:0]    tree_in_q, tree_in_d;
   logic [AccWidth-1:0]         acc_q, acc_d;
   logic [CntW-1:0]             feed_cnt_q, feed_cnt_d;
   logic [CntW-1:0]             sum_cnt_q, sum_cnt_d;
   logic                        out_valid_q, out_valid_d;
   logic [AccWidth-1:0]         out_data_q, out_data_d;

   logic                        in_ready_s;
   logic                        accept_s;
   logic signed [7:0]           partial_s;
   logic signed [AccWidth-1:0]  partial_ext_s;

   assign in_ready_s    = (state_q == ST_FEED) && !rst_in;
   assign accept_s      = in_valid && in_ready_s;
   assign partial_s     = tree_out;
   assign partial_ext_s = partial_s;

   // Next-state, feed and accumulate logic
   always_comb begin
      state_d     = state_q;
      tag_d       = tag_q << 1;
      tree_in_d   = '0;
      acc_d       = acc_q;
      feed_cnt_d  = feed_cnt_q;
      sum_cnt_d   = sum_cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      // The tag emerging from the last stage marks tree_out as a real chunk sum
      if (tag_q[TreeLatency]) begin
         acc_d     = acc_q + AccWidth'(partial_ext_s);
         sum_cnt_d = sum_cnt_q + CntW'(1);
         if (sum_cnt_q == LastIdx) begin
            out_data_d  = acc_d;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
         end else begin
            out_valid_d = out_valid_q;
         end
      end else begin
         acc_d = acc_q;
      end

      case (state_q)
         ST_FEED: begin
            if (accept_s) begin
               tree_in_d  = in_data;
               tag_d[0]   = 1'b1;
               feed_cnt_d = feed_cnt_q + CntW'(1);
               if (feed_cnt_q == LastIdx) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_FEED;
               end
            end else begin
               tag_d[0] = 1'b0;
            end
         end
         ST_DRAIN: begin
            tag_d[0] = 1'b0;
         end
         ST_DONE: begin
            tag_d[0] = 1'b0;
            if (out_ready) begin
               out_valid_d = 1'b0;
               acc_d       = '0;
               feed_cnt_d  = '0;
               sum_cnt_d   = '0;
               state_d     = ST_FEED;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_FEED;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= ST_FEED;
         tag_q       <= '0;
         tree_in_q   <= '0;
         acc_q       <= '0;
         feed_cnt_q  <= '0;
         sum_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         tag_q       <= tag_d;
         tree_in_q   <= tree_in_d;
         acc_q       <= acc_d;
         feed_cnt_q  <= feed_cnt_d;
         sum_cnt_q   <= sum_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign in_ready  = in_ready_s;
   assign tree_in   = tree_in_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = (state_q != ST_FEED) || (|tag_q);

endmodule

// File: tb/tb_vec_reduce_ctrl.sv
// Directed bench for vec_reduce_ctrl with a behavioural pipelined adder tree;
// a second instance with an 8-bit accumulator shares the stimulus.
module tb_vec_reduce_ctrl;

   localparam int ELEM = 12;
   localparam int VLEN = 48;
   localparam int TL   = 3;

   logic                      clk_in = 1'b0;
   logic                      rst_in;
   logic                      in_valid;
   logic [ELEM-1:0][7:0]      in_data;
   logic                      out_ready;

   logic                      in_ready, out_valid, busy;
   logic [ELEM-1:0][7:0]      tree_in;
   logic [7:0]                tree_out;
   logic [15:0]               out_data;

   logic                      in_ready8, out_valid8, busy8;
   logic [ELEM-1:0][7:0]      tree_in8;
   logic [7:0]                tree_out8;
   logic [7:0]                out_data8;

   logic [7:0]                tp   [TL];
   logic [7:0]                tp8  [TL];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_in = ~clk_in;

   vec_reduce_ctrl #(.Elements(ELEM), .VecLen(VLEN), .TreeLatency(TL), .AccWidth(16)) u_dut (
      .clk_in(clk_in), .rst_in(rst_in), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .tree_in(tree_in), .tree_out(tree_out), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   vec_reduce_ctrl #(.Elements(ELEM), .VecLen(VLEN), .TreeLatency(TL), .AccWidth(8)) u_dut8 (
      .clk_in(clk_in), .rst_in(rst_in), .in_valid(in_valid), .in_ready(in_ready8),
      .in_data(in_data), .tree_in(tree_in8), .tree_out(tree_out8), .out_valid(out_valid8),
      .out_ready(out_ready), .out_data(out_data8), .busy(busy8)
   );

   function automatic logic [7:0] tree_sum(input logic [ELEM-1:0][7:0] v);
      logic [7:0] s;
      s = 8'd0;
      for (int i = 0; i < ELEM; i++) s = s + v[i];
      return s;
   endfunction

   // Behavioural adder tree: combinational sum followed by TL register stages
   always_ff @(posedge clk_in) begin
      tp[0]  <= tree_sum(tree_in);
      tp8[0] <= tree_sum(tree_in8);
      for (int i = 1; i < TL; i++) begin
         tp[i]  <= tp[i-1];
         tp8[i] <= tp8[i-1];
      end
   end
   assign tree_out  = tp[TL-1];
   assign tree_out8 = tp8[TL-1];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic fill(input logic [7:0] val);
      for (int i = 0; i < ELEM; i++) in_data[i] = val;
   endtask

   // Feeds one vector of identical elements; returns the cycle out_valid first appears
   task automatic feed_vector(input logic [7:0] val, input bit toggle, output int lat);
      int  c;
      int  sent;
      bit  acc;
      c    = 0;
      sent = 0;
      lat  = -1;
      fill(val);
      while (lat < 0 && c < 60) begin
         in_valid = (sent < VLEN / ELEM) && (!toggle || (c % 2 == 0));
         acc      = in_valid && in_ready;
         tick();
         c++;
         if (acc) sent++;
         if (out_valid && lat < 0) lat = c;
      end
      in_valid = 1'b0;
   endtask

   initial begin
      int lat;
      rst_in    = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      fill(8'd0);
      tick();
      tick();
      check_eq("rst_in_ready",  32'(in_ready),        32'd0);
      check_eq("rst_tree_in",   32'(tree_in == '0),   32'd1);
      check_eq("rst_out_valid", 32'(out_valid),       32'd0);
      check_eq("rst_out_data",  32'(out_data),        32'd0);
      check_eq("rst_busy",      32'(busy),            32'd0);
      rst_in = 1'b0;
      #1;
      check_eq("post_rst_ready", 32'(in_ready), 32'd1);

      // All ones, back-to-back
      feed_vector(8'd1, 1'b0, lat);
      check_eq("ones_latency", 32'(lat), 32'd8);
      check_eq("ones_data",    32'(out_data), 32'd48);
      check_eq("ones_data8",   32'(out_data8), 32'h30);
      tick();
      check_eq("ones_valid_drop", 32'(out_valid), 32'd0);
      check_eq("ones_busy",       32'(busy),      32'd0);
      check_eq("ones_ready",      32'(in_ready),  32'd1);

      // 127s: each chunk sum wraps to -12 inside the tree
      feed_vector(8'd127, 1'b0, lat);
      check_eq("s127_data",  32'(out_data),  32'h0000FFD0);
      check_eq("s127_data8", 32'(out_data8), 32'hD0);
      tick();

      // -1s with a bubble every other cycle
      feed_vector(8'hFF, 1'b1, lat);
      check_eq("neg_bubble_latency", 32'(lat), 32'd11);
      check_eq("neg_bubble_data",    32'(out_data), 32'h0000FFD0);
      tick();

      // Back-pressure on the result, then a second vector
      out_ready = 1'b0;
      feed_vector(8'd1, 1'b0, lat);
      check_eq("bp_latency", 32'(lat), 32'd8);
      in_valid = 1'b1;
      fill(8'd9);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("bp_valid_hold", 32'(out_valid), 32'd1);
         check_eq("bp_data_hold",  32'(out_data),  32'd48);
         check_eq("bp_in_ready",   32'(in_ready),  32'd0);
         check_eq("bp_tree_idle",  32'(tree_in == '0), 32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check_eq("bp_release_valid", 32'(out_valid), 32'd0);
      check_eq("bp_release_ready", 32'(in_ready),  32'd1);
      feed_vector(8'd2, 1'b0, lat);
      check_eq("twos_data", 32'(out_data), 32'd96);
      tick();

      // Reset in the middle of a vector of 5s
      fill(8'd5);
      in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      rst_in   = 1'b1;
      #1;
      check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
      tick();
      check_eq("midrst_tree_in",   32'(tree_in == '0), 32'd1);
      check_eq("midrst_out_valid", 32'(out_valid),     32'd0);
      check_eq("midrst_out_data",  32'(out_data),      32'd0);
      check_eq("midrst_busy",      32'(busy),          32'd0);
      rst_in = 1'b0;
      feed_vector(8'd1, 1'b0, lat);
      check_eq("fresh_latency", 32'(lat), 32'd8);
      check_eq("fresh_data",    32'(out_data), 32'd48);
      tick();

      // 10s: exercises accumulator wrap in the 8-bit instance
      feed_vector(8'd10, 1'b0, lat);
      check_eq("tens_data8", 32'(out_data8), 32'hE0);
      check_eq("tens_data",  32'(out_data),  32'h1E0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
